// File: rtl/round_controller.sv
// round_controller: sequencing FSM for the cipher round datapath.
// Accepts a block on in_valid/in_ready, runs NUM_ROUNDS round cycles, then
// presents completion on out_valid/out_ready.
// Optional build macro ROUND_STALL_EN adds a 'stall' input that freezes
// round progress while asserted in the ROUND state.
module round_controller #(
  parameter int NUM_ROUNDS = 16,
  parameter int RND_BITS   = 5
) (
  input  logic                clk,
  input  logic                n_rst,
`ifdef ROUND_STALL_EN
  input  logic                stall,
`endif
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                ed_sel,
  input  logic                abort,
  output logic                load_data,
  output logic                cnt_clear,
  output logic                cnt_enable,
  output logic                round_en,
  output logic                final_round,
  output logic [RND_BITS-1:0] round_num,
  output logic                mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [RND_BITS-1:0] ROUNDS_C = RND_BITS'(NUM_ROUNDS);
  localparam logic [RND_BITS-1:0] ONE_C    = RND_BITS'(1);

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [RND_BITS-1:0] remaining_q, remaining_d;
  logic [RND_BITS-1:0] round_num_q, round_num_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                round_act_q, round_act_d;
  logic                final_q, final_d;
  logic                out_valid_q, out_valid_d;

  logic                stall_w;
  logic                accept;
  logic                kill;

`ifdef ROUND_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  // Accept only from IDLE, never under abort, and never while reset is held.
  assign accept = n_rst && (state_q == S_IDLE) && in_valid && !abort;
  // Abort cancels any in-flight operation; it is a no-op in IDLE.
  assign kill   = n_rst && (state_q != S_IDLE) && abort;

  assign load_data   = accept;
  assign cnt_clear   = accept | kill;
  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign out_valid   = out_valid_q;
  assign mode        = mode_q;
  assign round_num   = round_num_q;
  // A stalled round cycle does no work, so the round strobes are masked.
  assign round_en    = round_act_q & ~stall_w;
  assign cnt_enable  = round_act_q & ~stall_w;
  assign final_round = final_q & ~stall_w;

  // Next-state, round bookkeeping and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    remaining_d = remaining_q;
    round_num_d = round_num_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mode_d  = ed_sel;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d     = S_ROUND;
        remaining_d = ROUNDS_C;
        round_num_d = mode_q ? ROUNDS_C : ONE_C;
      end
      S_ROUND: begin
        if (!stall_w) begin
          remaining_d = remaining_q - ONE_C;
          if (remaining_q == ONE_C) begin
            // Last round: round_num keeps the final index through DONE.
            state_d = S_DONE;
          end else begin
            round_num_d = mode_q ? (round_num_q - ONE_C) : (round_num_q + ONE_C);
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (kill) begin
      state_d = S_IDLE;
    end

    // Moore outputs are registered from the next state so they line up
    // with the state they describe.
    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    round_act_d = (state_d == S_ROUND);
    final_d     = (state_d == S_ROUND) && (remaining_d == ONE_C);
    out_valid_d = (state_d == S_DONE);
  end

  // State and registered-output flops, cleared asynchronously to IDLE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      remaining_q <= '0;
      round_num_q <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      round_act_q <= 1'b0;
      final_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      remaining_q <= remaining_d;
      round_num_q <= round_num_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      round_act_q <= round_act_d;
      final_q     <= final_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// Testbench for round_controller: directed and randomized blocks checked
// against a cycle-indexed reference of the round sequence.
`timescale 1ns/1ps
module tb_round_controller;

  localparam int N  = 16;
  localparam int RB = 5;

  logic          clk;
  logic          n_rst;
  logic          in_valid;
  logic          in_ready;
  logic          ed_sel;
  logic          abort;
  logic          load_data;
  logic          cnt_clear;
  logic          cnt_enable;
  logic          round_en;
  logic          final_round;
  logic [RB-1:0] round_num;
  logic          mode;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
`ifdef ROUND_STALL_EN
  logic          stall;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  round_controller #(.NUM_ROUNDS(N), .RND_BITS(RB)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
`ifdef ROUND_STALL_EN
    .stall      (stall),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ed_sel     (ed_sel),
    .abort      (abort),
    .load_data  (load_data),
    .cnt_clear  (cnt_clear),
    .cnt_enable (cnt_enable),
    .round_en   (round_en),
    .final_round(final_round),
    .round_num  (round_num),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [RB-1:0] obs, input logic [RB-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; drive point is 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, "_in_ready"}, in_ready, 1'b1);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_out_valid"}, out_valid, 1'b0);
    chk1({tag, "_round_en"}, round_en, 1'b0);
    chk1({tag, "_cnt_enable"}, cnt_enable, 1'b0);
    chk1({tag, "_final"}, final_round, 1'b0);
  endtask

  // One block. kill_kind: 0 none, 1 abort, 2 reset, applied at round index
  // kill_at (1..N), or N+1 for the first DONE cycle (abort only).
  task automatic run_block(input logic ed, input int bp, input int kill_at,
                           input int kill_kind, input int stall_at, input int stall_len);
    int            i;
    int            stalled;
    logic          st;
    logic [RB-1:0] erm;
    i       = 1;
    stalled = 0;
    erm     = '0;

    // accept cycle
    in_valid  = 1'b1;
    ed_sel    = ed;
    abort     = 1'b0;
    out_ready = 1'($urandom_range(0, 1));
    #1;
    chk1("acc_in_ready", in_ready, 1'b1);
    chk1("acc_load_data", load_data, 1'b1);
    chk1("acc_cnt_clear", cnt_clear, 1'b1);
    chk1("acc_busy", busy, 1'b0);
    chk1("acc_out_valid", out_valid, 1'b0);
    tick();

    // load cycle; inputs after accept are noise
    in_valid  = 1'($urandom_range(0, 1));
    ed_sel    = 1'($urandom_range(0, 1));
    out_ready = 1'($urandom_range(0, 1));
    #1;
    chk1("load_in_ready", in_ready, 1'b0);
    chk1("load_busy", busy, 1'b1);
    chk1("load_load_data", load_data, 1'b0);
    chk1("load_cnt_clear", cnt_clear, 1'b0);
    chk1("load_round_en", round_en, 1'b0);
    chk1("load_mode", mode, ed);
    chk1("load_out_valid", out_valid, 1'b0);
    tick();

    // round cycles
    while (i <= N) begin
      in_valid  = 1'($urandom_range(0, 1));
      ed_sel    = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      erm       = ed ? RB'(N + 1 - i) : RB'(i);
      st        = (i == stall_at) && (stalled < stall_len);
`ifdef ROUND_STALL_EN
      stall = st;
`else
      st = 1'b0;
`endif
      if (kill_at == i && kill_kind == 1) begin
        abort = 1'b1;
        #1;
        chk1("abort_cnt_clear", cnt_clear, 1'b1);
        chkn("abort_round_num", round_num, erm);
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
`ifdef ROUND_STALL_EN
        stall = 1'b0;
`endif
        #1;
        chk_idle("post_abort");
        for (int k = 0; k < N + 3; k++) begin
          tick();
          #1;
          chk1("post_abort_no_out_valid", out_valid, 1'b0);
        end
        tick();
        return;
      end
      if (kill_at == i && kill_kind == 2) begin
        in_valid = 1'b1;
        n_rst    = 1'b0;
        #1;
        chk_idle("rst_mid");
        chk1("rst_mid_load_data", load_data, 1'b0);
        chk1("rst_mid_cnt_clear", cnt_clear, 1'b0);
        chkn("rst_mid_round_num", round_num, '0);
        chk1("rst_mid_mode", mode, 1'b0);
        tick();
        in_valid = 1'b0;
        n_rst    = 1'b1;
`ifdef ROUND_STALL_EN
        stall = 1'b0;
`endif
        #1;
        chk_idle("rst_release");
        tick();
        return;
      end
      #1;
      chk1("rnd_round_en", round_en, !st);
      chk1("rnd_cnt_enable", cnt_enable, !st);
      chk1("rnd_final", final_round, (i == N) && !st);
      chkn("rnd_round_num", round_num, erm);
      chk1("rnd_mode", mode, ed);
      chk1("rnd_busy", busy, 1'b1);
      chk1("rnd_in_ready", in_ready, 1'b0);
      chk1("rnd_out_valid", out_valid, 1'b0);
      chk1("rnd_load_data", load_data, 1'b0);
      chk1("rnd_cnt_clear", cnt_clear, 1'b0);
      tick();
      if (st) stalled++;
      else i++;
    end
`ifdef ROUND_STALL_EN
    stall = 1'b0;
`endif

    // done: erm holds the last round index
    if (kill_at == N + 1 && kill_kind == 1) begin
      out_ready = 1'b0;
      abort     = 1'b1;
      #1;
      chk1("done_abort_out_valid", out_valid, 1'b1);
      chk1("done_abort_cnt_clear", cnt_clear, 1'b1);
      tick();
      abort    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk_idle("post_done_abort");
      tick();
      return;
    end
    for (int k = 0; k < bp; k++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom_range(0, 1));
      #1;
      chk1("done_out_valid", out_valid, 1'b1);
      chk1("done_in_ready", in_ready, 1'b0);
      chk1("done_load_data", load_data, 1'b0);
      chk1("done_busy", busy, 1'b1);
      chk1("done_round_en", round_en, 1'b0);
      chkn("done_round_num", round_num, erm);
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'($urandom_range(0, 1));
    #1;
    chk1("done_hs_out_valid", out_valid, 1'b1);
    chk1("done_hs_load_data", load_data, 1'b0);
    chkn("done_hs_round_num", round_num, erm);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #1;
    chk_idle("after_done");
    tick();
  endtask

  initial begin
    n_rst     = 1'b0;
    in_valid  = 1'b0;
    ed_sel    = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
`ifdef ROUND_STALL_EN
    stall     = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #2;
    #1;
    chk_idle("reset");
    chkn("reset_round_num", round_num, '0);
    chk1("reset_mode", mode, 1'b0);
    chk1("reset_load_data", load_data, 1'b0);
    n_rst = 1'b1;
    tick();

    // encrypt, decrypt, output backpressure
    run_block(1'b0, 0, 0, 0, 0, 0);
    run_block(1'b1, 0, 0, 0, 0, 0);
    run_block(1'b0, 5, 0, 0, 0, 0);

    // abort while idle blocks the accept
    in_valid = 1'b1;
    abort    = 1'b1;
    #1;
    chk1("idle_abort_in_ready", in_ready, 1'b1);
    chk1("idle_abort_load_data", load_data, 1'b0);
    chk1("idle_abort_cnt_clear", cnt_clear, 1'b0);
    tick();
    in_valid = 1'b0;
    abort    = 1'b0;
    #1;
    chk_idle("idle_abort_next");
    tick();

    // abort at round 7, then a full block
    run_block(1'b0, 0, 7, 1, 0, 0);
    run_block(1'b0, 1, 0, 0, 0, 0);
    // abort in DONE
    run_block(1'b1, 0, N + 1, 1, 0, 0);
    // reset during round 9, then a full block
    run_block(1'b0, 0, 9, 2, 0, 0);
    run_block(1'b1, 2, 0, 0, 0, 0);
    // stall for 3 cycles at round 4 (no effect without the stall port)
    run_block(1'b0, 0, 0, 0, 4, 3);

    // randomized blocks
    for (int b = 0; b < 14; b++) begin
      logic ed;
      int   bp;
      int   ka;
      int   kk;
      ed = 1'($urandom_range(0, 1));
      bp = $urandom_range(0, 4);
      kk = ($urandom_range(0, 2) == 0) ? 1 : 0;
      ka = (kk != 0) ? $urandom_range(1, N + 1) : 0;
      run_block(ed, bp, ka, kk, $urandom_range(1, N), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
